// File: rtl/vga_timing_pkg.sv
// Shared types and default 800x600@72 raster geometry for the VGA timing sequencer.
package vga_timing_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  // Phase members carry a prefix so they cannot collide with the axis parameters.
  typedef enum logic [1:0] {PH_ACT, PH_FP, PH_SYNC, PH_BP} phase_t;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 56;
  localparam int H_SYNC_DEF   = 120;
  localparam int H_BP_DEF     = 64;
  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FP_DEF     = 37;
  localparam int V_SYNC_DEF   = 6;
  localparam int V_BP_DEF     = 23;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int CW_DEF       = 11;

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter with registered phase decode.
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int CW     = 11,
  parameter int ACTIVE = 800,
  parameter int FP     = 56,
  parameter int SYNC   = 120,
  parameter int BP     = 64
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          step,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic [1:0]    phase,
  output logic          active,
  output logic          sync,
  output logic          last
);

  localparam int            TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] FP_START   = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] BP_START   = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] count_q, count_d;
  phase_t        phase_q, phase_d;
  logic          live_q;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (step)
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
  end

  // Phase is decoded from the next count so it lands in step with the counter.
  always_comb begin
    phase_d = PH_BP;
    if (count_d < FP_START)
      phase_d = PH_ACT;
    else if (count_d < SYNC_START)
      phase_d = PH_FP;
    else if (count_d < BP_START)
      phase_d = PH_SYNC;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
      phase_q <= PH_ACT;
      live_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      live_q  <= !clear;
    end
  end

  assign count  = count_q;
  assign phase  = phase_q;
  assign active = live_q && (phase_q == PH_ACT);
  assign sync   = live_q && (phase_q == PH_SYNC);
  assign last   = (count_q == LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: run/stop control around the H and V axis counters.
//   state | meaning
//   IDLE  | counters parked at (0,0), outputs inactive
//   SCAN  | scanning, RUN held high
//   DRAIN | RUN dropped, finishing the current frame
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int SYNC_POL = 1,
  parameter int CW       = CW_DEF
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic          RUN,
  output logic          BUSY,
  output logic [CW-1:0] X,
  output logic [CW-1:0] Y,
  output logic          DE,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          LINE_START,
  output logic          FRAME_START
);

  state_t     state_q, state_d;
  logic       busy_q, ls_q, fs_q;
  logic       ls_d, fs_d;
  logic       h_step, v_step, clear, frame_wrap, start;
  logic       h_last, v_last, h_active, v_active, h_sync, v_sync;
  logic [1:0] h_phase, v_phase, unused_phase;

  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    h_step     = EN && (state_q != IDLE);
    v_step     = h_step && h_last;
    frame_wrap = h_step && h_last && v_last;
    case (state_q)
      IDLE: begin
        start = RUN;
        if (RUN) state_d = SCAN;
      end
      SCAN:  if (!RUN) state_d = DRAIN;
      DRAIN: begin
        if (RUN)
          state_d = SCAN;
        else if (frame_wrap)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Parking in IDLE also covers the final drain wrap: counters clear, no pulses.
    clear = (state_d == IDLE);
    ls_d  = start || (v_step && !clear);
    fs_d  = start || (frame_wrap && !clear);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  vga_axis_cnt #(.CW(CW), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .CLK(CLK), .RST(RST), .step(h_step), .clear(clear),
    .count(X), .phase(h_phase), .active(h_active), .sync(h_sync), .last(h_last)
  );

  vga_axis_cnt #(.CW(CW), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .CLK(CLK), .RST(RST), .step(v_step), .clear(clear),
    .count(Y), .phase(v_phase), .active(v_active), .sync(v_sync), .last(v_last)
  );

  assign unused_phase = h_phase ^ v_phase;

  assign BUSY        = busy_q;
  assign DE          = h_active && v_active;
  assign HSYNC       = (SYNC_POL != 0) ? h_sync : !h_sync;
  assign VSYNC       = (SYNC_POL != 0) ? v_sync : !v_sync;
  assign LINE_START  = ls_q;
  assign FRAME_START = fs_q;

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Sequencer for the VGA raster: owns the horizontal and vertical pixel counters and produces sync, display-enable and position outputs for the pixel pipeline and the DAC pins. It sits between the pixel-clock domain (`CLK`, gated by a pixel-tick enable) and the downstream pixel generator. A run/stop handshake lets the system start scanning cleanly and stop only on a frame boundary.

## Interface
- `H_ACTIVE`, 800: visible pixels per line.
- `H_FP`, 56: horizontal front porch, in pixels.
- `H_SYNC`, 120: horizontal sync width, in pixels.
- `H_BP`, 64: horizontal back porch, in pixels. `H_TOTAL` = 1040.
- `V_ACTIVE`, 600: visible lines.
- `V_FP`, 37: vertical front porch, in lines.
- `V_SYNC`, 6: vertical sync width, in lines.
- `V_BP`, 23: vertical back porch, in lines. `V_TOTAL` = 666.
- `SYNC_POL`, 1: active level of `HSYNC`/`VSYNC`; 1 means active-high.
- `CW`, 11: counter width; must satisfy 2^CW ≥ max(`H_TOTAL`, `V_TOTAL`).

Ports:
- `CLK` in 1: clock. There is one clock; reset is synchronous and active-high.
- `RST` in 1: synchronous reset, active-high.
- `EN` in 1: pixel tick. The counters advance only on edges where `EN`=1.
- `RUN` in 1: request to scan; level-sensitive.
- `BUSY` out 1: high while a frame is being scanned (`SCAN` or `DRAIN`).
- `X` out CW: current horizontal count, 0..`H_TOTAL`-1.
- `Y` out CW: current vertical count, 0..`V_TOTAL`-1.
- `DE` out 1: display enable, high when `X`<`H_ACTIVE` and `Y`<`V_ACTIVE`.
- `HSYNC` out 1: horizontal sync, at the polarity set by `SYNC_POL`.
- `VSYNC` out 1: vertical sync, at the polarity set by `SYNC_POL`.
- `LINE_START` out 1: one-`CLK` pulse when `X` becomes 0 while `BUSY`.
- `FRAME_START` out 1: one-`CLK` pulse when (`X`,`Y`) becomes (0,0) while `BUSY`.

## Operation
- Control FSM states: `IDLE`, `SCAN`, `DRAIN`. Reset enters `IDLE`.
- `IDLE`:
  - X=Y=0, DE=0, syncs inactive, BUSY=0.
  - `RUN`=1 moves to `SCAN` on the next edge, regardless of `EN`. That edge sets FRAME_START=1 and LINE_START=1, with (X,Y)=(0,0).
- `SCAN`: each `EN` edge does X←X+1.
  - At X=`H_TOTAL`-1: X←0, Y←Y+1, LINE_START pulse.
  - At (X,Y)=(`H_TOTAL`-1,`V_TOTAL`-1): wrap to (0,0) with FRAME_START and LINE_START.
  - `RUN`=0 moves to `DRAIN` with no change to the counters.
- `DRAIN`: counts exactly as in `SCAN`.
  - `RUN`=1 returns to `SCAN` seamlessly.
  - On the final frame wrap, go to `IDLE` instead: (0,0), no pulses, syncs inactive.
- Frames are never truncated by `RUN`; only `RST` truncates a frame.
- Sync regions:
  - HSYNC is active for X in [`H_ACTIVE`+`H_FP`, `H_ACTIVE`+`H_FP`+`H_SYNC`-1], i.e. 856..975.
  - VSYNC is active for Y in [`V_ACTIVE`+`V_FP`, ...+`V_SYNC`-1], i.e. 637..642. It is evaluated on Y only, for whole lines.
- Arithmetic: region bounds are compile-time constants of width CW. Counters are unsigned and never exceed TOTAL-1 (no 2^CW overflow).

## Timing
- All outputs are flops updated on the same edge as X/Y. DE, HSYNC, VSYNC, the pulses and BUSY are consistent with the X/Y values present in the same cycle, with zero relative latency.
- Reset values: X=0, Y=0, DE=0, HSYNC=VSYNC=!`SYNC_POL`, LINE_START=FRAME_START=0, BUSY=0.
- `EN`=0: all state is held, and LINE_START/FRAME_START are forced to 0 after one cycle. Pulses are never longer than one `CLK` cycle.
- `RST` has priority over `EN` and `RUN` on the same edge. Reset mid-frame returns to the reset values next cycle; there is no partial pulse.
- `RUN` rising and falling in the same `IDLE` cycle: only the sampled level counts. One cycle high starts a frame, which then runs to completion in `DRAIN`.
- Frame period with `EN`=1 always: 1040×666 = 692,640 `CLK` cycles.

## Structure
- Shared package `vga_timing_pkg` holds:
  - the FSM state enum (`IDLE`/`SCAN`/`DRAIN`);
  - the axis phase enum (`ACT`/`FP`/`SYNC`/`BP`);
  - the 800×600@72 default constants and derived `H_TOTAL`/`V_TOTAL`.
- Sub-module `vga_axis_cnt`, instantiated twice (H and V), with parameters ACTIVE/FP/SYNC/BP.
  - Inputs: step, clear.
  - Outputs: count, phase, active, sync, last (count = TOTAL-1).
  - The V instance steps on the H instance's `last`&`EN`.

## Test plan
- Reset, `RUN`=0, 100 cycles → X=Y=0, DE=0, HSYNC=VSYNC=0 (with `SYNC_POL`=1), BUSY=0, no pulses.
- `RUN`=1, `EN`=1 → FRAME_START on the first cycle. DE high for X 0..799 on line 0, HSYNC high for exactly X 856..975. X 1039→0 with Y 0→1 and a single LINE_START.
- Run a full frame → VSYNC high for Y 637..642 only. (1039,665)→(0,0) with FRAME_START. DE never high for Y≥600.
- `EN` toggling 1,0,1,0 → X advances once per two cycles. LINE_START lasts exactly one cycle even when `EN`=0 follows.
- Drop `RUN` at (400,300) → scanning continues to (1039,665), then IDLE: BUSY=0, X=Y=0, no FRAME_START. Re-raising `RUN` at (0,500) while in `DRAIN` → no gap at the wrap, FRAME_START is seen.
- Assert `RST` at (900,640), during HSYNC and VSYNC → next cycle shows all reset values, syncs inactive.
